// File: rtl/alu_defs.sv
// rtl/alu_defs.sv - shared ALU control and sequencer state encodings
package alu_defs;

  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_OR  = 3'd5;
  localparam logic [2:0] ALU_NOR = 3'd6;
  localparam logic [2:0] ALU_XOR = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Carry and overflow only carry meaning for the adder operations.
  function automatic logic is_arith(input logic [2:0] c);
    return (c == ALU_ADD) || (c == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu1.sv
// rtl/alu1.sv - one-bit ALU slice
module alu1
  import alu_defs::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] control,
  output logic       result,
  output logic       cout
);

  logic bx;
  logic sum;
  logic carry;

  // B is inverted for SUB; the +1 of two's complement comes in through cin.
  always_comb begin
    bx     = b ^ (control == ALU_SUB);
    sum    = a ^ bx ^ cin;
    carry  = (a & bx) | (cin & (a ^ bx));
    result = 1'b0;
    cout   = 1'b0;
    case (control)
      ALU_ADD, ALU_SUB: begin
        result = sum;
        cout   = carry;
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOR: result = ~(a | b);
      ALU_XOR: result = a ^ b;
      default: begin
        result = 1'b0;
        cout   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/serial_alu_seq.sv
// rtl/serial_alu_seq.sv - bit-serial ALU sequencer driving one alu1 slice LSB first
module serial_alu_seq
  import alu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state;
  state_e           next_state;
  logic             accept;
  logic             step;
  logic             finish;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic [2:0]       op;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             slice_res;
  logic             slice_cout;

  alu1 u_alu1 (
    .a       (a_sh[0]),
    .b       (b_sh[0]),
    .cin     (carry),
    .control (op),
    .result  (slice_res),
    .cout    (slice_cout)
  );

  assign res_next = {slice_res, res_sh[WIDTH-1:1]};
  assign ready    = (state != RUN);

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state plus the capture/step/finish strobes for the datapath.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) begin
          finish     = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = RUN;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand shifting, carry chaining, result assembly and flag capture.
  // On the last bit, carry still holds the MSB carry-in, so overflow is
  // formed from it and the slice carry-out without a separate latch.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      op       <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
      out      <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
      negative <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        a_sh     <= A;
        b_sh     <= B;
        op       <= control;
        carry    <= (control == ALU_SUB);
        cnt      <= '0;
        res_sh   <= '0;
        out      <= '0;
        carryout <= 1'b0;
        overflow <= 1'b0;
        zero     <= 1'b0;
        negative <= 1'b0;
      end else if (step) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        res_sh <= res_next;
        carry  <= slice_cout;
        cnt    <= cnt + 1'b1;
        if (finish) begin
          out      <= res_next;
          carryout <= is_arith(op) & slice_cout;
          overflow <= is_arith(op) & (carry ^ slice_cout);
          zero     <= (res_next == '0);
          negative <= slice_res;
        end
      end
    end
  end

endmodule
